// File: rtl/layer_mask_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : layer_mask_accumulate
// Desc     : Mask-gated CHANNELS-wide accumulator, DEPTH beats per start/done
//            pass. Define ACC_SATURATE_EN for saturating adds (default wraps).
// Revision : 1.0
// ============================================================================
module layer_mask_accumulate #(
   parameter int CHANNELS    = 5,
   parameter int SIZE        = 8,
   parameter int FRAC_BITS   = 4,
   parameter int OUTPUT_SIZE = 16,
   parameter int DEPTH       = 256
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [CHANNELS*SIZE-1:0]        vector_input,
   input  logic                            mask_input,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [CHANNELS*OUTPUT_SIZE-1:0] accumulate_out,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            busy
);

   localparam int              CNT_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [CHANNELS*SIZE-1:0] vec_q, vec_d;
   logic                     mask_q, mask_d;
   logic                     stg_valid_q, stg_valid_d;
   logic                     clear_acc;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      vec_d       = vec_q;
      mask_d      = mask_q;
      stg_valid_d = 1'b0;
      clear_acc   = 1'b0;
      in_ready    = (state_q == RUN);
      case (state_q)
         IDLE: begin
            if (start) begin
               clear_acc = 1'b1;
               count_d   = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (in_valid) begin
               vec_d       = vector_input;
               mask_d      = mask_input;
               stg_valid_d = 1'b1;
               count_d     = count_q + 1'b1;
               if (count_q == LAST_COUNT) state_d = DRAIN;
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         count_q     <= '0;
         vec_q       <= '0;
         mask_q      <= 1'b0;
         stg_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         vec_q       <= vec_d;
         mask_q      <= mask_d;
         stg_valid_q <= stg_valid_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);

   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic        [OUTPUT_SIZE-1:0] acc_q, acc_d;
      logic signed [OUTPUT_SIZE-1:0] term;
`ifdef ACC_SATURATE_EN
      logic [OUTPUT_SIZE:0] sum;
`endif

      always_comb begin
         term = '0;
         if (mask_q) term = OUTPUT_SIZE'($signed(vec_q[k*SIZE +: SIZE])) <<< FRAC_BITS;
         acc_d = acc_q;
`ifdef ACC_SATURATE_EN
         // One guard bit: top two bits disagreeing means the add left the range.
         sum = {acc_q[OUTPUT_SIZE-1], acc_q} + {term[OUTPUT_SIZE-1], term};
         if (clear_acc) begin
            acc_d = '0;
         end else if (stg_valid_q) begin
            if (sum[OUTPUT_SIZE] != sum[OUTPUT_SIZE-1])
               acc_d = sum[OUTPUT_SIZE] ? {1'b1, {(OUTPUT_SIZE-1){1'b0}}}
                                        : {1'b0, {(OUTPUT_SIZE-1){1'b1}}};
            else
               acc_d = sum[OUTPUT_SIZE-1:0];
         end
`else
         if (clear_acc)        acc_d = '0;
         else if (stg_valid_q) acc_d = acc_q + term;
`endif
      end

      always_ff @(posedge clk) begin
         if (reset) acc_q <= '0;
         else       acc_q <= acc_d;
      end

      assign accumulate_out[k*OUTPUT_SIZE +: OUTPUT_SIZE] = acc_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_layer_mask_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_mask_accumulate
// Desc     : Scoreboard bench for layer_mask_accumulate (DEPTH=4 main instance,
//            OUTPUT_SIZE=12/DEPTH=2 overflow instance; honours ACC_SATURATE_EN).
// Revision : 1.0
// ============================================================================
module tb_layer_mask_accumulate;
   localparam int CH = 5, SZ = 8, OS = 16, DP = 4, OS_B = 12, DP_B = 2;

   logic clk = 1'b0;
   logic reset, start, mask_input, in_valid, out_ready;
   logic [CH*SZ-1:0] vector_input;
   logic in_ready, out_valid, busy;
   logic [CH*OS-1:0] accumulate_out;

   logic start_b, mask_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
   logic [CH*SZ-1:0]   vector_b;
   logic [CH*OS_B-1:0] acc_out_b;

   int errors = 0;
   int checks = 0;
   logic [CH*OS-1:0]     exp_q[$];
   logic signed [OS-1:0] model_acc[CH];

   localparam logic [CH*OS-1:0] BASIC_EXP = {16'h0140, 16'h0100, 16'h00C0, 16'h0080, 16'h0040};
`ifdef ACC_SATURATE_EN
   localparam logic [OS_B-1:0] OVF_POS_EXP = 12'h7FF;
   localparam logic [OS_B-1:0] OVF_NEG_EXP = 12'h800;
`else
   localparam logic [OS_B-1:0] OVF_POS_EXP = 12'hFE0;
   localparam logic [OS_B-1:0] OVF_NEG_EXP = 12'h000;
`endif

   always #5 clk = ~clk;

   layer_mask_accumulate #(.CHANNELS(CH), .SIZE(SZ), .FRAC_BITS(4), .OUTPUT_SIZE(OS), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .start(start), .vector_input(vector_input),
      .mask_input(mask_input), .in_valid(in_valid), .in_ready(in_ready),
      .accumulate_out(accumulate_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   layer_mask_accumulate #(.CHANNELS(CH), .SIZE(SZ), .FRAC_BITS(4), .OUTPUT_SIZE(OS_B), .DEPTH(DP_B)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .vector_input(vector_b),
      .mask_input(mask_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .accumulate_out(acc_out_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_clear();
      for (int k = 0; k < CH; k++) model_acc[k] = '0;
   endfunction

   function automatic void model_beat(input logic [CH*SZ-1:0] v, input logic m);
      logic signed [OS-1:0] t;
      for (int k = 0; k < CH; k++) begin
         t = OS'($signed(v[k*SZ +: SZ]));
         if (m) model_acc[k] = model_acc[k] + t * 16'sd16;
      end
   endfunction

   function automatic void model_push();
      logic [CH*OS-1:0] p;
      for (int k = 0; k < CH; k++) p[k*OS +: OS] = model_acc[k];
      exp_q.push_back(p);
   endfunction

   task automatic begin_pass();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_out(input int bound, output int n);
      n = 0;
      while (out_valid !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mask_input = 1'b0; vector_input = '0;
      start_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; mask_b = 1'b0; vector_b = '0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (accumulate_out !== '0) begin errors++; $display("FAIL reset_acc: got %h expected 0", accumulate_out); end
      checks++; if ({in_ready_b, out_valid_b, busy_b} !== 3'b000) begin errors++;
         $display("FAIL reset_b_ctrl: got %b expected 000", {in_ready_b, out_valid_b, busy_b}); end
   endtask

   task automatic test_basic();
      logic [CH*SZ-1:0] v;
      logic [CH*OS-1:0] e;
      for (int k = 0; k < CH; k++) v[k*SZ +: SZ] = SZ'(k + 1);
      model_clear();
      begin_pass();
      checks++; if (in_ready !== 1'b1 || busy !== 1'b1) begin errors++;
         $display("FAIL basic_run_c1: got ready=%b busy=%b expected 1 1", in_ready, busy); end
      in_valid = 1'b1; vector_input = v; mask_input = 1'b1;
      for (int b = 0; b < DP; b++) begin model_beat(v, 1'b1); tick(); end
      model_push();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++;
         $display("FAIL basic_drain: got valid=%b ready=%b expected 0 0", out_valid, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid_c6: got %b expected 1", out_valid); end
      if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL basic_sb: scoreboard empty"); end
      else begin
         e = exp_q.pop_front();
         checks++; if (accumulate_out !== e) begin errors++; $display("FAIL basic_data: got %h expected %h", accumulate_out, e); end
      end
      checks++; if (accumulate_out !== BASIC_EXP) begin errors++;
         $display("FAIL basic_const: got %h expected %h", accumulate_out, BASIC_EXP); end
      in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL basic_release: got valid=%b busy=%b expected 0 0", out_valid, busy); end
   endtask

   task automatic test_negative();
      logic [CH*SZ-1:0] v;
      logic [CH*OS-1:0] e;
      logic m[DP] = '{1'b1, 1'b0, 1'b1, 1'b0};
      v[SZ-1:0] = 8'hFF;
      for (int k = 1; k < CH; k++) v[k*SZ +: SZ] = SZ'($urandom_range(0, 255));
      model_clear();
      begin_pass();
      in_valid = 1'b1; vector_input = v;
      for (int b = 0; b < DP; b++) begin mask_input = m[b]; model_beat(v, m[b]); tick(); end
      model_push();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL neg_drain: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL neg_out_valid: got %b expected 1", out_valid); end
      checks++; if (accumulate_out[OS-1:0] !== 16'hFFE0) begin errors++;
         $display("FAIL neg_ch0: got %h expected ffe0", accumulate_out[OS-1:0]); end
      if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL neg_sb: scoreboard empty"); end
      else begin
         e = exp_q.pop_front();
         checks++; if (accumulate_out !== e) begin errors++; $display("FAIL neg_data: got %h expected %h", accumulate_out, e); end
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_bubbles();
      logic [CH*SZ-1:0] v;
      logic [CH*OS-1:0] e;
      logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < CH; k++) v[k*SZ +: SZ] = SZ'(k + 1);
      model_clear();
      begin_pass();
      vector_input = v; mask_input = 1'b1;
      for (int s = 0; s < 7; s++) begin
         in_valid = pat[s];
         if (pat[s]) model_beat(v, 1'b1);
         tick();
         if (s == 5) begin
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bub_still_run: got %b expected 1", in_ready); end
         end
      end
      model_push();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_drain: got %b expected 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bub_out_valid: got %b expected 1", out_valid); end
      if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL bub_sb: scoreboard empty"); end
      else begin
         e = exp_q.pop_front();
         checks++; if (accumulate_out !== e) begin errors++; $display("FAIL bub_data: got %h expected %h", accumulate_out, e); end
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [CH*SZ-1:0] v;
      logic [CH*OS-1:0] e;
      logic m;
      int n;
      model_clear();
      begin_pass();
      in_valid = 1'b1;
      for (int b = 0; b < DP; b++) begin
         for (int k = 0; k < CH; k++) v[k*SZ +: SZ] = SZ'($urandom_range(0, 255));
         m = 1'($urandom_range(0, 1));
         vector_input = v; mask_input = m;
         model_beat(v, m);
         tick();
      end
      model_push();
      in_valid = 1'b0;
      wait_out(5, n);
      checks++; if (n != 1) begin errors++; $display("FAIL bp_latency: got %0d expected 1", n); end
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      out_ready = 1'b0; start = 1'b1; in_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: cycle %0d got %b expected 1", c, out_valid); end
         checks++; if (accumulate_out !== e) begin errors++; $display("FAIL bp_data_hold: cycle %0d got %h expected %h", c, accumulate_out, e); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b expected 0", c, in_ready); end
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", out_valid, busy); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_restart: got busy=%b expected 0", busy); end
   endtask

   task automatic test_reset_midpass();
      logic [CH*SZ-1:0] v;
      logic [CH*OS-1:0] e;
      int n;
      begin_pass();
      in_valid = 1'b1; mask_input = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int k = 0; k < CH; k++) v[k*SZ +: SZ] = SZ'($urandom_range(1, 127));
         vector_input = v;
         tick();
      end
      in_valid = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if ({in_ready, out_valid, busy} !== 3'b000) begin errors++;
         $display("FAIL rst_mid_ctrl: got %b expected 000", {in_ready, out_valid, busy}); end
      checks++; if (accumulate_out !== '0) begin errors++; $display("FAIL rst_mid_acc: got %h expected 0", accumulate_out); end
      model_clear();
      begin_pass();
      in_valid = 1'b1;
      for (int b = 0; b < DP; b++) begin
         for (int k = 0; k < CH; k++) v[k*SZ +: SZ] = SZ'($urandom_range(0, 255));
         vector_input = v; mask_input = 1'b1;
         model_beat(v, 1'b1);
         tick();
      end
      model_push();
      in_valid = 1'b0;
      wait_out(5, n);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_timeout: got %b expected 1", out_valid); end
      if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL rst_mid_sb: scoreboard empty"); end
      else begin
         e = exp_q.pop_front();
         checks++; if (accumulate_out !== e) begin errors++; $display("FAIL rst_mid_data: got %h expected %h", accumulate_out, e); end
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      vector_b = {8'h04, 8'h01, 8'h80, 8'h00, 8'h7F};
      mask_b = 1'b1; in_valid_b = 1'b1;
      tick(); tick();
      in_valid_b = 1'b0;
      checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL ovf_drain: got %b expected 0", out_valid_b); end
      tick();
      checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL ovf_out_valid: got %b expected 1", out_valid_b); end
      checks++; if (acc_out_b[OS_B-1:0] !== OVF_POS_EXP) begin errors++;
         $display("FAIL ovf_pos: got %h expected %h", acc_out_b[OS_B-1:0], OVF_POS_EXP); end
      checks++; if (acc_out_b[2*OS_B +: OS_B] !== OVF_NEG_EXP) begin errors++;
         $display("FAIL ovf_neg: got %h expected %h", acc_out_b[2*OS_B +: OS_B], OVF_NEG_EXP); end
      checks++; if (acc_out_b[3*OS_B +: OS_B] !== 12'h020 || acc_out_b[4*OS_B +: OS_B] !== 12'h080) begin errors++;
         $display("FAIL ovf_inrange: got %h %h expected 020 080", acc_out_b[3*OS_B +: OS_B], acc_out_b[4*OS_B +: OS_B]); end
      out_ready_b = 1'b1; tick(); out_ready_b = 1'b0;
      checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL ovf_release: got %b expected 0", out_valid_b); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_bubbles();
      test_backpressure();
      test_reset_midpass();
      test_overflow();
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/layer_mask_accumulate.md
# layer_mask_accumulate

Parametrised mask-gated accumulator for the first fully connected layer of the semeion accelerator. It takes CHANNELS signed fixed-point vector elements per beat, gated by one binary pixel mask bit, and accumulates DEPTH beats per neuron pass. Input and output use valid/ready handshakes. A start/done sequence replaces free-running accumulation and sits between the weight/pixel streamer and the layer-2 activation stage.

## Interface
- CHANNELS, 5, number of parallel neuron accumulators
- SIZE, 8, width of each signed input element
- FRAC_BITS, 4, left shift applied to an element (fixed-point multiply by 1.0)
- OUTPUT_SIZE, 16, width of each signed accumulator; must be ≥ SIZE+FRAC_BITS
- DEPTH, 256, beats per pass; must be ≥ 1
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  begin a pass; sampled only in IDLE
- vector_input  input  CHANNELS*SIZE  packed elements; channel k at [k*SIZE +: SIZE]
- mask_input  input  1  pixel bit for this beat
- in_valid  input  1  beat present
- in_ready  output  1  block accepts a beat
- accumulate_out  output  CHANNELS*OUTPUT_SIZE  packed accumulators; channel k at [k*OUTPUT_SIZE +: OUTPUT_SIZE]
- out_valid  output  1  accumulate_out holds a complete pass
- out_ready  input  1  consumer takes the result
- busy  output  1  state ≠ IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start=1: clear all accumulators and the beat counter, then go to RUN. Accumulators otherwise hold their last result.
- RUN: in_ready=1. A beat is accepted on in_valid&&in_ready. Each accepted beat is registered with vector_input, mask_input and a stage-valid bit, and the beat counter increments. Accepting beat DEPTH-1 sends the FSM to DRAIN.
- DRAIN lasts one cycle: in_ready=0 while the final registered beat is added. The FSM then goes to DONE.
- DONE: out_valid=1 and accumulate_out is stable. On out_ready=1 the FSM goes to IDLE. start is ignored in RUN, DRAIN and DONE.
- Per-channel term:
  - mask=1: the term is element k sign-extended to OUTPUT_SIZE after appending FRAC_BITS zeros.
  - mask=0: the term is 0.
  - Every channel uses its own element.
- Adding a term to a channel: the accumulator adds the term when the stage-valid bit is set. Two's-complement arithmetic at OUTPUT_SIZE applies (see Configuration).
- Mask=0 beats are still accepted and counted.

## Timing
- Reset values:
  - Outputs: in_ready=0, out_valid=0, busy=0, all accumulate_out=0.
  - Internal state: IDLE, counter 0, stage-valid 0.
- Reset mid-pass: on the next edge the block is in the reset state and the partial result is discarded.
- start sampled at edge 0 → RUN and in_ready=1 from cycle 1.
- Beat accepted at edge t → registered at edge t → added at edge t+1.
- Throughput is 1 beat/cycle.
- Last beat accepted at edge t → DRAIN during cycle t+1 → out_valid=1 from cycle t+2.
- With in_valid held high, out_valid asserts DEPTH+2 cycles after the start edge.
- out_valid and accumulate_out hold until out_ready. out_valid drops the cycle after the edge where out_ready=1 is sampled.
- busy falls together with out_valid.
- in_valid in IDLE, DRAIN or DONE is ignored; no beat is accepted.

## Configuration
- ACC_SATURATE_EN defined: each add saturates.
  - Positive overflow clamps to 2^(OUTPUT_SIZE-1)-1.
  - Negative overflow clamps to -2^(OUTPUT_SIZE-1).
  - The accumulator stays clamped until a later term moves it back in range.
- ACC_SATURATE_EN undefined: the add wraps modulo 2^OUTPUT_SIZE.

## Test plan
- Defaults except DEPTH=4:
  - Stimulus: channel k element=k+1, mask=1 for all 4 beats, in_valid held high.
  - Required: out_valid at cycle 6; accumulators 0x0040, 0x0080, 0x00C0, 0x0100, 0x0140.
- Negative values, DEPTH=4:
  - Stimulus: channel 0 element=0xFF, masks 1,0,1,0.
  - Required: channel 0 result 0xFFE0 (-32); pass still ends after 4 beats.
- Input bubbles:
  - Stimulus: in_valid pattern 1,0,0,1,1,0,1.
  - Required: exactly 4 beats counted; out_valid 2 cycles after the 4th accept; result equals the no-bubble case.
- Output backpressure:
  - Stimulus: out_ready=0 for 10 cycles in DONE, start pulsed, in_valid=1.
  - Required: out_valid and data stable; in_ready=0; no new pass starts. IDLE follows out_ready=1.
- Overflow, OUTPUT_SIZE=12, DEPTH=2:
  - Stimulus: element 0x7F, mask=1 for both beats.
  - Required: with ACC_SATURATE_EN, 0x7FF; without it, 0xFE0.
- Reset mid-pass:
  - Stimulus: reset asserted after 2 beats.
  - Required: next cycle all outputs 0 and state IDLE. A subsequent full pass gives a correct, uncontaminated result.
